// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: load-use bubbles, taken-branch flushes, data-memory freezes and a timeout trap.
// Latency: enables/bubble/flush are combinational (same cycle); state, wait_cnt, stall_cycles registered.
// Backpressure: mem_ready=0 freezes all pipeline registers until the access completes or times out.
module hazard_stall_controller #(
   parameter int REG_W        = 4,
   parameter int BASE_REG     = 10,
   parameter int MAX_MEM_WAIT = 15
) (
   input  logic             clk,
   input  logic             rest,
   input  logic [REG_W-1:0] IFID_Register_Rd,
   input  logic [REG_W-1:0] IFID_Register_Rt,
   input  logic             IFIDMemRead,
   input  logic             IFIDMemWrite,
   input  logic [REG_W-1:0] IDEX_Register_Rd,
   input  logic             IDEXMemRead,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IDEXWrite,
   output logic             EXMEMWrite,
   output logic             IDEXBubble,
   output logic             IFIDFlush,
   output logic             mem_timeout,
   output logic [7:0]       stall_cycles
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   localparam logic [REG_W-1:0] BASE_ADDR  = REG_W'(BASE_REG);
   localparam logic [7:0]       WAIT_LIMIT = 8'(MAX_MEM_WAIT);

   state_t     state;
   state_t     state_nxt;
   state_t     dec_state;
   logic [7:0] wait_cnt;
   logic [7:0] wait_cnt_nxt;
   logic       timeout_nxt;
   logic       load_use;
   logic       freeze;
   logic       hazard_decode;

   // Load in EX whose destination is a source of the ID instruction (r0 never hazards).
   always_comb begin
      load_use = IDEXMemRead && (IDEX_Register_Rd != '0) &&
                 ((IDEX_Register_Rd == IFID_Register_Rd) ||
                  (IDEX_Register_Rd == IFID_Register_Rt) ||
                  ((IDEX_Register_Rd == BASE_ADDR) && (IFIDMemRead || IFIDMemWrite)));
   end

   // Next-state and same-cycle enable decode; reset cycle decodes as RUN.
   always_comb begin
      dec_state     = rest ? state : RUN;
      state_nxt     = dec_state;
      wait_cnt_nxt  = wait_cnt;
      timeout_nxt   = mem_timeout;
      freeze        = 1'b0;
      hazard_decode = 1'b0;
      PCWrite       = 1'b1;
      IFIDWrite     = 1'b1;
      IDEXWrite     = 1'b1;
      EXMEMWrite    = 1'b1;
      IDEXBubble    = 1'b0;
      IFIDFlush     = 1'b0;

      case (dec_state)
         RUN: begin
            if (mem_req && !mem_ready) begin
               freeze       = 1'b1;
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = 8'd1;
            end else begin
               hazard_decode = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (!mem_ready) begin
               // EX is frozen, so branch/load-use inputs are stale and ignored.
               freeze       = 1'b1;
               wait_cnt_nxt = wait_cnt + 8'd1;
               if (wait_cnt == WAIT_LIMIT) begin
                  state_nxt   = ERR;
                  timeout_nxt = 1'b1;
               end
            end else begin
               // Freeze releases; the access is not re-issued this cycle.
               hazard_decode = 1'b1;
               state_nxt     = RUN;
               wait_cnt_nxt  = 8'd0;
            end
         end
         default: begin
            freeze      = 1'b1;
            timeout_nxt = 1'b1;
         end
      endcase

      if (freeze) begin
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IDEXWrite  = 1'b0;
         EXMEMWrite = 1'b0;
      end else if (hazard_decode) begin
         // A taken branch discards the ID instruction, so its load-use hazard is moot.
         if (branch_taken) begin
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
         end else if (load_use) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
         end
      end
   end

   // State, wait counter and sticky timeout registers.
   always_ff @(posedge clk) begin
      if (!rest) begin
         state       <= RUN;
         wait_cnt    <= 8'd0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         mem_timeout <= timeout_nxt;
      end
   end

   // Saturating count of cycles where the PC was held.
   always_ff @(posedge clk) begin
      if (!rest) begin
         stall_cycles <= 8'd0;
      end else if (!PCWrite && (stall_cycles != 8'hFF)) begin
         stall_cycles <= stall_cycles + 8'd1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed scenarios then random traffic vs a behavioural model.
// Outputs sampled on the falling edge; registered counters also checked 1 time unit after rising edge.
// Model tracks access streaks and a dead flag rather than the controller's state encoding.
module tb_hazard_stall_controller;

   localparam int REG_W        = 4;
   localparam int BASE_REG     = 10;
   localparam int MAX_MEM_WAIT = 15;

   logic             clk = 1'b0;
   logic             rest;
   logic [REG_W-1:0] IFID_Register_Rd;
   logic [REG_W-1:0] IFID_Register_Rt;
   logic             IFIDMemRead;
   logic             IFIDMemWrite;
   logic [REG_W-1:0] IDEX_Register_Rd;
   logic             IDEXMemRead;
   logic             branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             PCWrite;
   logic             IFIDWrite;
   logic             IDEXWrite;
   logic             EXMEMWrite;
   logic             IDEXBubble;
   logic             IFIDFlush;
   logic             mem_timeout;
   logic [7:0]       stall_cycles;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit m_known  = 1'b0;
   bit m_dead   = 1'b0;
   bit m_frozen = 1'b0;
   int m_streak = 0;
   int m_stalls = 0;

   hazard_stall_controller #(
      .REG_W       (REG_W),
      .BASE_REG    (BASE_REG),
      .MAX_MEM_WAIT(MAX_MEM_WAIT)
   ) dut (
      .clk             (clk),
      .rest            (rest),
      .IFID_Register_Rd(IFID_Register_Rd),
      .IFID_Register_Rt(IFID_Register_Rt),
      .IFIDMemRead     (IFIDMemRead),
      .IFIDMemWrite    (IFIDMemWrite),
      .IDEX_Register_Rd(IDEX_Register_Rd),
      .IDEXMemRead     (IDEXMemRead),
      .branch_taken    (branch_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .PCWrite         (PCWrite),
      .IFIDWrite       (IFIDWrite),
      .IDEXWrite       (IDEXWrite),
      .EXMEMWrite      (EXMEMWrite),
      .IDEXBubble      (IDEXBubble),
      .IFIDFlush       (IFIDFlush),
      .mem_timeout     (mem_timeout),
      .stall_cycles    (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rest             = 1'b1;
      IFID_Register_Rd = '0;
      IFID_Register_Rt = '0;
      IFIDMemRead      = 1'b0;
      IFIDMemWrite     = 1'b0;
      IDEX_Register_Rd = '0;
      IDEXMemRead      = 1'b0;
      branch_taken     = 1'b0;
      mem_req          = 1'b0;
      mem_ready        = 1'b0;
   endtask

   // One clock: predict outputs from current inputs, compare, advance model, step past the edge.
   task automatic cycle();
      bit reads_hit, lu, freeze, decode;
      bit e_pc, e_ifid, e_idex, e_exmem, e_bub, e_flush;
      @(negedge clk);
      // Registers the ID instruction actually reads: Rd, Rt, and the base register for memory ops.
      reads_hit = (IDEX_Register_Rd == IFID_Register_Rd) || (IDEX_Register_Rd == IFID_Register_Rt) ||
                  ((int'(IDEX_Register_Rd) == BASE_REG) && (IFIDMemRead || IFIDMemWrite));
      lu = IDEXMemRead && (IDEX_Register_Rd != 0) && reads_hit;

      freeze = 1'b0;
      decode = 1'b0;
      if (rest && m_dead) freeze = 1'b1;
      else if (rest && m_frozen) begin
         if (!mem_ready) freeze = 1'b1; else decode = 1'b1;
      end else begin
         if (mem_req && !mem_ready) freeze = 1'b1; else decode = 1'b1;
      end

      {e_pc, e_ifid, e_idex, e_exmem, e_bub, e_flush} = 6'b111100;
      if (freeze) {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
      else if (decode && branch_taken) {e_bub, e_flush} = 2'b11;
      else if (decode && lu) {e_pc, e_ifid, e_bub} = 3'b001;

      check("PCWrite", PCWrite, e_pc);
      check("IFIDWrite", IFIDWrite, e_ifid);
      check("IDEXWrite", IDEXWrite, e_idex);
      check("EXMEMWrite", EXMEMWrite, e_exmem);
      check("IDEXBubble", IDEXBubble, e_bub);
      check("IFIDFlush", IFIDFlush, e_flush);
      if (m_known) begin
         check("stall_cycles", stall_cycles, m_stalls);
         check("mem_timeout", mem_timeout, m_dead);
      end

      if (!rest) begin
         m_known  = 1'b1;
         m_dead   = 1'b0;
         m_frozen = 1'b0;
         m_streak = 0;
         m_stalls = 0;
      end else begin
         if (!e_pc && m_stalls < 255) m_stalls++;
         if (!m_dead) begin
            if (freeze) begin
               m_frozen = 1'b1;
               m_streak++;
               if (m_streak > MAX_MEM_WAIT) m_dead = 1'b1;
            end else begin
               m_frozen = 1'b0;
               m_streak = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pool [5];
      pool = '{0, 1, 2, 3, 10};

      // Reset held two cycles while an access is pending.
      idle();
      rest = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
      cycle();
      cycle();
      check("reset_stall_cycles", stall_cycles, 0);
      check("reset_mem_timeout", mem_timeout, 0);
      idle();
      cycle();

      // Load-use on Rt, then the bubble clears it.
      idle();
      IDEXMemRead = 1'b1; IDEX_Register_Rd = 4'd3; IFID_Register_Rt = 4'd3; IFID_Register_Rd = 4'd1;
      cycle();
      IDEXMemRead = 1'b0;
      cycle();
      check("loaduse_stall_cycles", stall_cycles, 1);

      // Base-register hazard for a store in ID, then the same with r0.
      idle();
      IDEX_Register_Rd = 4'd10; IDEXMemRead = 1'b1; IFIDMemWrite = 1'b1;
      IFID_Register_Rd = 4'd2; IFID_Register_Rt = 4'd5;
      cycle();
      IDEX_Register_Rd = 4'd0;
      cycle();
      check("basereg_stall_cycles", stall_cycles, 2);

      // Taken branch overrides a load-use condition.
      idle();
      branch_taken = 1'b1; IDEXMemRead = 1'b1; IDEX_Register_Rd = 4'd3; IFID_Register_Rd = 4'd3;
      cycle();
      idle();
      cycle();

      // Single-cycle access in RUN: no stall.
      mem_req = 1'b1; mem_ready = 1'b1;
      cycle();
      check("single_cycle_access", stall_cycles, 2);

      // Three not-ready cycles then ready.
      idle();
      mem_req = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      mem_ready = 1'b1;
      cycle();
      check("memwait_stall_cycles", stall_cycles, 5);
      idle();
      cycle();

      // Timeout: stays clear through the limit, trips one cycle later.
      idle();
      mem_req = 1'b1;
      for (int i = 0; i < MAX_MEM_WAIT; i++) cycle();
      check("timeout_not_yet", mem_timeout, 0);
      cycle();
      check("timeout_set", mem_timeout, 1);
      mem_ready = 1'b1; mem_req = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      check("timeout_sticky", mem_timeout, 1);
      for (int i = 0; i < 260; i++) cycle();
      check("stall_saturated", stall_cycles, 255);
      idle();
      rest = 1'b0;
      cycle();
      idle();
      cycle();
      check("timeout_cleared", mem_timeout, 0);
      check("stall_cleared", stall_cycles, 0);

      // Random traffic against the model.
      for (int n = 0; n < 800; n++) begin
         rest             = ($urandom_range(0, 49) != 0);
         IFID_Register_Rd = REG_W'(pool[$urandom_range(0, 4)]);
         IFID_Register_Rt = REG_W'(pool[$urandom_range(0, 4)]);
         IDEX_Register_Rd = REG_W'(pool[$urandom_range(0, 4)]);
         IFIDMemRead      = ($urandom_range(0, 3) == 0);
         IFIDMemWrite     = ($urandom_range(0, 3) == 0);
         IDEXMemRead      = ($urandom_range(0, 1) == 0);
         branch_taken     = ($urandom_range(0, 5) == 0);
         mem_req          = ($urandom_range(0, 3) == 0);
         mem_ready        = ($urandom_range(0, 1) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
